load_store_unit: RTL and testbench

//  CPU-side initiator for the data-memory request interface (Addr/WriteD/Mread/Mwrite/funct3 -> ReadD/Mready).

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: registers one access, holds it on the memory port until Mready_i,
// stalls the pipeline meanwhile. Optional misaligned-access trap enabled by `define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValid_i,
    input  logic        ReqWrite_i,
    input  logic [31:0] ReqAddr_i,
    input  logic [31:0] ReqWData_i,
    input  logic [2:0]  ReqFunct3_i,
    output logic        Stall_o,
    output logic        RespValid_o,
    output logic [31:0] RespData_o,
    output logic        Err_o,
    output logic [1:0]  ErrCode_o,
    output logic        Mread_o,
    output logic        Mwrite_o,
    output logic [31:0] Addr_o,
    output logic [31:0] WriteD_o,
    output logic [2:0]  Funct3_o,
    input  logic [31:0] ReadD_i,
    input  logic        Mready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_MISALIGN = 2'b10
    } err_code_t;

    localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state_q, state_d;
    logic             write_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       funct3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      resp_data_q;
    logic             err_q;
    err_code_t        err_code_q;

    logic misalign;
    logic timeout_hit;

`ifdef LSU_MISALIGN_TRAP_EN
    // Width encoded in funct3[1:0]; the 64-bit encoding is never legal on this datapath.
    always_comb begin
        misalign = 1'b0;
        unique case (ReqFunct3_i[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ReqAddr_i[0];
            2'b10:   misalign = |ReqAddr_i[1:0];
            default: misalign = 1'b1;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ReqValid_i) begin
                    state_d = misalign ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (Mready_i || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (ReqValid_i) begin
                        write_q  <= ReqWrite_i;
                        addr_q   <= ReqAddr_i;
                        wdata_q  <= ReqWData_i;
                        funct3_q <= ReqFunct3_i;
                        cnt_q    <= '0;
                        if (misalign) begin
                            resp_data_q <= '0;
                            err_q       <= 1'b1;
                            err_code_q  <= ERR_MISALIGN;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Mready_i takes priority over a watchdog expiry in the same cycle.
                    if (Mready_i) begin
                        resp_data_q <= write_q ? 32'd0 : ReadD_i;
                        err_q       <= 1'b0;
                        err_code_q  <= ERR_NONE;
                    end else if (timeout_hit) begin
                        resp_data_q <= '0;
                        err_q       <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Mread_o     = (state_q == BUSY) && !write_q;
    assign Mwrite_o    = (state_q == BUSY) &&  write_q;
    assign Addr_o      = addr_q;
    assign WriteD_o    = wdata_q;
    assign Funct3_o    = funct3_q;
    assign Stall_o     = ((state_q == IDLE) && ReqValid_i) || (state_q == BUSY);
    assign RespValid_o = (state_q == DONE);
    assign RespData_o  = resp_data_q;
    assign Err_o       = err_q;
    assign ErrCode_o   = err_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of directed accesses plus hand-written
// back-to-back and reset-mid-access sequences. Watchdog instantiated with TIMEOUT_CYCLES=8.
module tb_load_store_unit;

    localparam int TO = 8;
    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid_i;
    logic        ReqWrite_i;
    logic [31:0] ReqAddr_i;
    logic [31:0] ReqWData_i;
    logic [2:0]  ReqFunct3_i;
    logic        Stall_o;
    logic        RespValid_o;
    logic [31:0] RespData_o;
    logic        Err_o;
    logic [1:0]  ErrCode_o;
    logic        Mread_o;
    logic        Mwrite_o;
    logic [31:0] Addr_o;
    logic [31:0] WriteD_o;
    logic [2:0]  Funct3_o;
    logic [31:0] ReadD_i;
    logic        Mready_i;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ReqValid_i  (ReqValid_i),
        .ReqWrite_i  (ReqWrite_i),
        .ReqAddr_i   (ReqAddr_i),
        .ReqWData_i  (ReqWData_i),
        .ReqFunct3_i (ReqFunct3_i),
        .Stall_o     (Stall_o),
        .RespValid_o (RespValid_o),
        .RespData_o  (RespData_o),
        .Err_o       (Err_o),
        .ErrCode_o   (ErrCode_o),
        .Mread_o     (Mread_o),
        .Mwrite_o    (Mwrite_o),
        .Addr_o      (Addr_o),
        .WriteD_o    (WriteD_o),
        .Funct3_o    (Funct3_o),
        .ReadD_i     (ReadD_i),
        .Mready_i    (Mready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic        mis;
    } vec_t;

    vec_t vecs[9];

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3);
        ReqValid_i  = 1'b1;
        ReqWrite_i  = wr;
        ReqAddr_i   = addr;
        ReqWData_i  = wdata;
        ReqFunct3_i = f3;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_d;
        logic        exp_e;
        logic [1:0]  exp_c;
        bit          trapped;
        trapped = TRAP && v.mis;
        exp_d = trapped ? 32'd0 : v.exp_data;
        exp_e = trapped ? 1'b1  : v.exp_err;
        exp_c = trapped ? 2'b10 : v.exp_code;

        @(negedge clk);
        drive_req(v.wr, v.addr, v.wdata, v.f3);
        Mready_i = 1'b0;
        ReadD_i  = 32'hBAD0_0000 + idx;
        #1;
        check($sformatf("v%0d req stall", idx), Stall_o, 1);
        check($sformatf("v%0d req mread", idx), Mread_o, 0);
        check($sformatf("v%0d req mwrite", idx), Mwrite_o, 0);
        check($sformatf("v%0d req respvalid", idx), RespValid_o, 0);

        if (!trapped) begin
            for (int k = 0; k < TO; k++) begin
                @(negedge clk);
                // Scramble request inputs: the memory port must keep the latched access.
                ReqAddr_i   = ~v.addr;
                ReqWData_i  = ~v.wdata;
                ReqFunct3_i = ~v.f3;
                ReqWrite_i  = ~v.wr;
                Mready_i    = (k == v.delay);
                ReadD_i     = (k == v.delay) ? v.rdata : 32'h5A5A_0000 + k;
                #1;
                check($sformatf("v%0d busy%0d mread", idx, k), Mread_o, !v.wr);
                check($sformatf("v%0d busy%0d mwrite", idx, k), Mwrite_o, v.wr);
                check($sformatf("v%0d busy%0d addr", idx, k), Addr_o, v.addr);
                check($sformatf("v%0d busy%0d wdata", idx, k), WriteD_o, v.wdata);
                check($sformatf("v%0d busy%0d funct3", idx, k), Funct3_o, v.f3);
                check($sformatf("v%0d busy%0d stall", idx, k), Stall_o, 1);
                check($sformatf("v%0d busy%0d respvalid", idx, k), RespValid_o, 0);
                if (k == v.delay) break;
            end
        end

        @(negedge clk);
        drive_req(v.wr, v.addr, v.wdata, v.f3);
        Mready_i = 1'b0;
        ReadD_i  = 32'hFFFF_FFFF;
        #1;
        check($sformatf("v%0d done respvalid", idx), RespValid_o, 1);
        check($sformatf("v%0d done data", idx), RespData_o, exp_d);
        check($sformatf("v%0d done err", idx), Err_o, exp_e);
        check($sformatf("v%0d done code", idx), ErrCode_o, exp_c);
        check($sformatf("v%0d done stall", idx), Stall_o, 0);
        check($sformatf("v%0d done mread", idx), Mread_o, 0);
        check($sformatf("v%0d done mwrite", idx), Mwrite_o, 0);

        @(negedge clk);
        ReqValid_i = 1'b0;
        #1;
        check($sformatf("v%0d idle respvalid", idx), RespValid_o, 0);
        check($sformatf("v%0d idle data held", idx), RespData_o, exp_d);
        check($sformatf("v%0d idle err held", idx), Err_o, exp_e);
        check($sformatf("v%0d idle code held", idx), ErrCode_o, exp_c);
        check($sformatf("v%0d idle stall", idx), Stall_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //           wr    addr          wdata          f3    delay  rdata          exp_data       err   code   mis
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         3'd2, 0,     32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 3'd2, 5,     32'h7777_7777, 32'h0,         1'b0, 2'b00, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0040, 32'h0,         3'd2, NEVER, 32'h0,         32'h0,         1'b1, 2'b01, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0003, 32'h0,         3'd0, 2,     32'hFFFF_FF80, 32'hFFFF_FF80, 1'b0, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0004, 32'h0000_BEEF, 3'd1, 0,     32'h3333_3333, 32'h0,         1'b0, 2'b00, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0006, 32'h0,         3'd5, 7,     32'h0000_BEEF, 32'h0000_BEEF, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0102, 32'h0,         3'd2, 1,     32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2'b00, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0007, 32'h0000_1234, 3'd1, 0,     32'h4444_4444, 32'h0,         1'b0, 2'b00, 1'b1};
        vecs[8] = '{1'b0, 32'h0000_0008, 32'h0,         3'd3, 0,     32'h0000_0011, 32'h0000_0011, 1'b0, 2'b00, 1'b1};

        rst = 1'b1;
        ReqValid_i = 1'b0; ReqWrite_i = 1'b0; ReqAddr_i = '0; ReqWData_i = '0;
        ReqFunct3_i = '0; ReadD_i = '0; Mready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", Stall_o, 0);
        check("reset respvalid", RespValid_o, 0);
        check("reset data", RespData_o, 0);
        check("reset err", {Err_o, ErrCode_o}, 0);
        check("reset mem port", {Mread_o, Mwrite_o, Funct3_o}, 0);
        check("reset addr", Addr_o, 0);
        check("reset wdata", WriteD_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back: LB 0x3 then SH 0x4, both hit; pulses expected 3 cycles apart.
        @(negedge clk); drive_req(1'b0, 32'h3, 32'h0, 3'd0); Mready_i = 1'b0; #1;
        check("b2b c0 stall", Stall_o, 1);
        @(negedge clk); Mready_i = 1'b1; ReadD_i = 32'h0000_0041; #1;
        check("b2b c1 mread", Mread_o, 1);
        check("b2b c1 addr", Addr_o, 32'h3);
        @(negedge clk); Mready_i = 1'b0; ReadD_i = 32'h0; #1;
        check("b2b c2 respvalid", RespValid_o, 1);
        check("b2b c2 data", RespData_o, 32'h41);
        check("b2b c2 stall", Stall_o, 0);
        @(negedge clk); drive_req(1'b1, 32'h4, 32'h0000_ABCD, 3'd1); #1;
        check("b2b c3 respvalid", RespValid_o, 0);
        check("b2b c3 mem idle", {Mread_o, Mwrite_o}, 0);
        check("b2b c3 stall", Stall_o, 1);
        @(negedge clk); Mready_i = 1'b1; ReadD_i = 32'h9999_9999; #1;
        check("b2b c4 mwrite", {Mread_o, Mwrite_o}, 2'b01);
        check("b2b c4 addr", Addr_o, 32'h4);
        check("b2b c4 wdata", WriteD_o, 32'h0000_ABCD);
        check("b2b c4 respvalid", RespValid_o, 0);
        @(negedge clk); Mready_i = 1'b0; #1;
        check("b2b c5 respvalid", RespValid_o, 1);
        check("b2b c5 data", RespData_o, 0);
        @(negedge clk); ReqValid_i = 1'b0; #1;
        check("b2b c6 respvalid", RespValid_o, 0);

        // Leave an error latched, then reset on the second BUSY cycle of a new load.
        run_vec(2, vecs[2]);
        @(negedge clk); drive_req(1'b0, 32'h100, 32'h0, 3'd2); Mready_i = 1'b0; #1;
        @(negedge clk); #1;
        check("rst c1 mread", Mread_o, 1);
        @(negedge clk); rst = 1'b1; #1;
        check("rst c2 mread", Mread_o, 1);
        @(negedge clk); rst = 1'b0; ReqValid_i = 1'b0; #1;
        check("rst c3 mread", Mread_o, 0);
        check("rst c3 stall", Stall_o, 0);
        check("rst c3 respvalid", RespValid_o, 0);
        check("rst c3 err", {Err_o, ErrCode_o}, 0);
        @(negedge clk); #1;
        check("rst c4 respvalid", RespValid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
